sweep_ctrl: RTL

// Sequences one parameter sweep through the cost-function evaluation pipeline that feeds the best-solution tracker.

---
 rtl/sweep_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/sweep_ctrl.sv
// Sequences one p0-index sweep through the cost-function evaluator with credit-limited issue,
// then closes the sweep toward the best-solution tracker with latch_o and clear_o pulses.
module sweep_ctrl #(
  parameter int IDX_W   = 8,
  parameter int CNT_W   = 9,
  parameter int CREDITS = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [IDX_W-1:0] idx_start_i,
  input  logic [CNT_W-1:0] idx_count_i,
  input  logic             eval_ready_i,
  output logic             issue_o,
  output logic [IDX_W-1:0] issue_idx_o,
  input  logic             res_valid_i,
  input  logic [IDX_W-1:0] res_idx_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] p0_idx_o,
  output logic             latch_o,
  output logic             clear_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [2:0]       dbg_state_o
);

  // Handshake: an issue transfers on issue_o & eval_ready_i, and issue_o/issue_idx_o hold
  // until it does; results carry no back-pressure, res_valid_i is consumed whenever it is high.

  localparam int OUT_W = $clog2(CREDITS + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_LATCH = 3'd3,
    S_CLEAR = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_remaining;
  logic [OUT_W-1:0] r_outstanding;
  logic [TMR_W-1:0] r_timer;
  logic             r_err;
  logic             r_quiet;

  logic w_active;
  logic w_xfer;
  logic w_res_ok;
  logic w_res_bad;
  logic w_last_xfer;
  logic w_timeout;

  assign w_active    = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign w_xfer      = issue_o & eval_ready_i;
  assign w_res_ok    = w_active & res_valid_i & (r_outstanding != '0);
  assign w_res_bad   = w_active & res_valid_i & (r_outstanding == '0);
  assign w_last_xfer = w_xfer & (r_remaining == CNT_W'(1));
  // A drain stalls only while results are still owed; abort takes precedence.
  assign w_timeout   = (r_state == S_DRAIN) & ~res_valid_i & ~abort_i &
                       (r_outstanding != '0) & (r_timer == TMR_W'(TIMEOUT - 1));

  always_comb begin
    w_state_nxt = r_state;
    issue_o     = 1'b0;
    latch_o     = 1'b0;
    clear_o     = 1'b0;
    done_o      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) w_state_nxt = (idx_count_i == '0) ? S_LATCH : S_ISSUE;
      end
      S_ISSUE: begin
        issue_o = (r_outstanding < OUT_W'(CREDITS));
        if (abort_i)          w_state_nxt = S_CLEAR;
        else if (w_last_xfer) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort_i)                     w_state_nxt = S_CLEAR;
        else if (r_outstanding == '0)    w_state_nxt = S_LATCH;
        else if (w_timeout)              w_state_nxt = S_CLEAR;
      end
      S_LATCH: begin
        latch_o     = 1'b1;
        w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        clear_o     = 1'b1;
        done_o      = ~r_quiet;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_remaining   <= '0;
      r_outstanding <= '0;
      r_timer       <= '0;
      r_err         <= 1'b0;
      r_quiet       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_idx         <= idx_start_i;
            r_remaining   <= idx_count_i;
            r_outstanding <= '0;
            r_timer       <= '0;
            r_err         <= 1'b0;
            r_quiet       <= 1'b0;
          end
        end
        S_ISSUE, S_DRAIN: begin
          if (w_xfer) begin
            r_idx       <= r_idx + IDX_W'(1);
            r_remaining <= r_remaining - CNT_W'(1);
          end
          if (w_xfer && !w_res_ok)      r_outstanding <= r_outstanding + OUT_W'(1);
          else if (!w_xfer && w_res_ok) r_outstanding <= r_outstanding - OUT_W'(1);
          // The idle timer only runs in DRAIN; any returning result restarts it.
          if (res_valid_i || r_state == S_ISSUE) r_timer <= '0;
          else                                   r_timer <= r_timer + TMR_W'(1);
          if (w_res_bad) r_err <= 1'b1;
          if (abort_i)   r_quiet <= 1'b1;
          if (w_timeout) begin
            r_err   <= 1'b1;
            r_quiet <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign issue_idx_o = r_idx;
  assign valid_o     = w_res_ok;
  assign p0_idx_o    = res_idx_i;
  assign busy_o      = (r_state != S_IDLE);
  assign err_o       = r_err;
  assign dbg_state_o = r_state;

endmodule
